// File: rtl/sha1m_pkg.sv
// Shared types and constants for the SHA-1 metric datapath.
//   HASH_W    hash width in bits; also the largest legal metric value
//   MW        metric width, wide enough to carry out-of-range metrics
//   NONCE_W   candidate nonce width
package sha1m_pkg;

  localparam int unsigned HASH_W  = 160;
  localparam int unsigned MW      = $clog2(HASH_W + 1) + 1;
  localparam int unsigned NONCE_W = 64;

  typedef logic [MW-1:0]      metric_t;
  typedef logic [NONCE_W-1:0] nonce_t;

  localparam metric_t MaxMetric = metric_t'(HASH_W);

  // Clamp an illegal metric to the full-match value.
  function automatic metric_t sat_metric(input metric_t m);
    return (m > MaxMetric) ? MaxMetric : m;
  endfunction

endpackage

// File: rtl/cand_delay.sv
// LAT-stage shift register of {valid, nonce}.
// The last stage lines a candidate up with its metric from the metric block.
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   flush_i         synchronous flush of every stage valid
//   valid_i/nonce_i candidate entering the line
//   valid_o/nonce_o candidate leaving stage LAT
module cand_delay
  import sha1m_pkg::*;
#(
  parameter int unsigned LAT = 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               valid_i,
  input  logic [NONCE_W-1:0] nonce_i,
  output logic               valid_o,
  output logic [NONCE_W-1:0] nonce_o
);

  logic [LAT-1:0] valid_q;
  nonce_t         nonce_q [LAT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < int'(LAT); i++) begin
        nonce_q[i] <= '0;
      end
    end else if (flush_i) begin
      valid_q <= '0;
    end else begin
      for (int i = int'(LAT) - 1; i > 0; i--) begin
        valid_q[i] <= valid_q[i-1];
        nonce_q[i] <= nonce_q[i-1];
      end
      valid_q[0] <= valid_i;
      nonce_q[0] <= nonce_i;
    end
  end

  assign valid_o = valid_q[LAT-1];
  assign nonce_o = nonce_q[LAT-1];

endmodule

// File: rtl/best_tracker.sv
// Tracks the best (highest) metric seen and its nonce, and offers improvements
// at or above threshold_i to the host over a one-entry valid/ready report register.
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              synchronous clear of all tracking state
//   cand_valid_i/nonce_i candidate issued to the metric block
//   metric_i             metric of the candidate issued LAT cycles earlier
//   threshold_i          minimum metric worth reporting
//   best_*_o             best metric/nonce so far, valid once anything evaluated
//   rpt_*                report channel (valid/ready, metric, nonce)
//   found_o              sticky full-match flag
//   drop_o               pulse: pending report overwritten before acceptance
//   cand_count_o         saturating count of evaluated candidates
module best_tracker
  import sha1m_pkg::*;
#(
  parameter int unsigned LAT   = 1,
  parameter int unsigned CNT_W = 48
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               cand_valid_i,
  input  logic [NONCE_W-1:0] cand_nonce_i,
  input  logic [MW-1:0]      metric_i,
  input  logic [MW-1:0]      threshold_i,
  output logic               best_valid_o,
  output logic [MW-1:0]      best_metric_o,
  output logic [NONCE_W-1:0] best_nonce_o,
  output logic               rpt_valid_o,
  input  logic               rpt_ready_i,
  output logic [MW-1:0]      rpt_metric_o,
  output logic [NONCE_W-1:0] rpt_nonce_o,
  output logic               found_o,
  output logic               drop_o,
  output logic [CNT_W-1:0]   cand_count_o
);

  logic   v_d;
  nonce_t n_d;

  cand_delay #(
    .LAT (LAT)
  ) u_cand_delay (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clear_i),
    .valid_i (cand_valid_i),
    .nonce_i (cand_nonce_i),
    .valid_o (v_d),
    .nonce_o (n_d)
  );

  logic             best_valid_q, best_valid_d;
  metric_t          best_metric_q, best_metric_d;
  nonce_t           best_nonce_q, best_nonce_d;
  logic             rpt_valid_q, rpt_valid_d;
  metric_t          rpt_metric_q, rpt_metric_d;
  nonce_t           rpt_nonce_q, rpt_nonce_d;
  logic             found_q, found_d;
  logic             drop_q, drop_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  metric_t m_eff;
  logic    better;
  logic    load;

  assign m_eff  = sat_metric(metric_i);
  // Strictly greater: a tie keeps the older nonce.
  assign better = !best_valid_q || (m_eff > best_metric_q);
  assign load   = v_d && better && (m_eff >= threshold_i);

  always_comb begin
    best_valid_d  = best_valid_q;
    best_metric_d = best_metric_q;
    best_nonce_d  = best_nonce_q;
    rpt_valid_d   = rpt_valid_q;
    rpt_metric_d  = rpt_metric_q;
    rpt_nonce_d   = rpt_nonce_q;
    found_d       = found_q;
    drop_d        = 1'b0;
    cnt_d         = cnt_q;

    if (clear_i) begin
      best_valid_d  = 1'b0;
      best_metric_d = '0;
      best_nonce_d  = '0;
      rpt_valid_d   = 1'b0;
      rpt_metric_d  = '0;
      rpt_nonce_d   = '0;
      found_d       = 1'b0;
      cnt_d         = '0;
    end else begin
      if (v_d) begin
        if (!(&cnt_q)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (better) begin
          best_valid_d  = 1'b1;
          best_metric_d = m_eff;
          best_nonce_d  = n_d;
        end
        if (m_eff == MaxMetric) begin
          found_d = 1'b1;
        end
      end
      if (load) begin
        // Overwriting an unaccepted report loses it; accepting in the same cycle does not.
        drop_d       = rpt_valid_q && !rpt_ready_i;
        rpt_valid_d  = 1'b1;
        rpt_metric_d = m_eff;
        rpt_nonce_d  = n_d;
      end else if (rpt_valid_q && rpt_ready_i) begin
        rpt_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      best_valid_q  <= 1'b0;
      best_metric_q <= '0;
      best_nonce_q  <= '0;
      rpt_valid_q   <= 1'b0;
      rpt_metric_q  <= '0;
      rpt_nonce_q   <= '0;
      found_q       <= 1'b0;
      drop_q        <= 1'b0;
      cnt_q         <= '0;
    end else begin
      best_valid_q  <= best_valid_d;
      best_metric_q <= best_metric_d;
      best_nonce_q  <= best_nonce_d;
      rpt_valid_q   <= rpt_valid_d;
      rpt_metric_q  <= rpt_metric_d;
      rpt_nonce_q   <= rpt_nonce_d;
      found_q       <= found_d;
      drop_q        <= drop_d;
      cnt_q         <= cnt_d;
    end
  end

  assign best_valid_o  = best_valid_q;
  assign best_metric_o = best_metric_q;
  assign best_nonce_o  = best_nonce_q;
  assign rpt_valid_o   = rpt_valid_q;
  assign rpt_metric_o  = rpt_metric_q;
  assign rpt_nonce_o   = rpt_nonce_q;
  assign found_o       = found_q;
  assign drop_o        = drop_q;
  assign cand_count_o  = cnt_q;

endmodule

// File: tb/tb_best_tracker.sv
// Two instances share one stimulus stream: index 0 is LAT=1/CNT_W=48,
// index 1 is LAT=3/CNT_W=4. Each is compared against a history-based model.
module tb_best_tracker;
  import sha1m_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n;
  logic    clear;
  logic    cand_valid;
  nonce_t  cand_nonce;
  metric_t metric;
  metric_t threshold;
  logic    rpt_ready;

  logic        bv [2];
  metric_t     bm [2];
  nonce_t      bn [2];
  logic        rv [2];
  metric_t     rm [2];
  nonce_t      rn [2];
  logic        fnd[2];
  logic        drp[2];
  logic [47:0] cnt1;
  logic [3:0]  cnt3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  best_tracker #(.LAT(1), .CNT_W(48)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .cand_valid_i(cand_valid),
    .cand_nonce_i(cand_nonce), .metric_i(metric), .threshold_i(threshold),
    .best_valid_o(bv[0]), .best_metric_o(bm[0]), .best_nonce_o(bn[0]),
    .rpt_valid_o(rv[0]), .rpt_ready_i(rpt_ready), .rpt_metric_o(rm[0]),
    .rpt_nonce_o(rn[0]), .found_o(fnd[0]), .drop_o(drp[0]), .cand_count_o(cnt1)
  );

  best_tracker #(.LAT(3), .CNT_W(4)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .cand_valid_i(cand_valid),
    .cand_nonce_i(cand_nonce), .metric_i(metric), .threshold_i(threshold),
    .best_valid_o(bv[1]), .best_metric_o(bm[1]), .best_nonce_o(bn[1]),
    .rpt_valid_o(rv[1]), .rpt_ready_i(rpt_ready), .rpt_metric_o(rm[1]),
    .rpt_nonce_o(rn[1]), .found_o(fnd[1]), .drop_o(drp[1]), .cand_count_o(cnt3)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          lat    [2] = '{1, 3};
  longint      cnt_max[2] = '{64'(48'hFFFF_FFFF_FFFF), 15};
  bit          m_bv[2], m_rv[2], m_found[2], m_drop[2];
  int          m_bm[2], m_rm[2];
  logic [63:0] m_bn[2], m_rn[2];
  longint      m_cnt[2];
  bit          hist_v[$];
  logic [63:0] hist_n[$];
  int          cyc = 0;
  int          last_clear = -1;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_bv[k] = 0; m_bm[k] = 0; m_bn[k] = '0;
      m_rv[k] = 0; m_rm[k] = 0; m_rn[k] = '0;
      m_found[k] = 0; m_drop[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int          s;
    bit          v;
    logic [63:0] n;
    int          m;
    bit          load;
    s = cyc - lat[k];
    v = (s >= 0) && (s > last_clear) && hist_v[s];
    n = (s >= 0) ? hist_n[s] : '0;
    m = (int'(metric) > int'(HASH_W)) ? int'(HASH_W) : int'(metric);
    m_drop[k] = 0;
    load = 0;
    if (v) begin
      if (m_cnt[k] < cnt_max[k]) m_cnt[k]++;
      if (!m_bv[k] || m > m_bm[k]) begin
        m_bv[k] = 1; m_bm[k] = m; m_bn[k] = n;
        load = (m >= int'(threshold));
      end
      if (m == int'(HASH_W)) m_found[k] = 1;
    end
    if (load) begin
      if (m_rv[k] && !rpt_ready) m_drop[k] = 1;
      m_rv[k] = 1; m_rm[k] = m; m_rn[k] = n;
    end else if (m_rv[k] && rpt_ready) begin
      m_rv[k] = 0;
    end
  endtask

  always @(posedge clk) begin
    hist_v.push_back(cand_valid);
    hist_n.push_back(cand_nonce);
    if (!rst_n || clear) begin
      model_reset();
      last_clear = cyc;
    end else begin
      model_step(0);
      model_step(1);
    end
    cyc++;
  end

  task automatic check_dut(input int k);
    logic [63:0] c;
    c = (k == 0) ? 64'(cnt1) : 64'(cnt3);
    check_eq($sformatf("d%0d.best_valid", k), 64'(bv[k]), 64'(m_bv[k]));
    check_eq($sformatf("d%0d.best_metric", k), 64'(bm[k]), 64'(m_bm[k]));
    check_eq($sformatf("d%0d.best_nonce", k), bn[k], m_bn[k]);
    check_eq($sformatf("d%0d.rpt_valid", k), 64'(rv[k]), 64'(m_rv[k]));
    if (m_rv[k]) begin
      check_eq($sformatf("d%0d.rpt_metric", k), 64'(rm[k]), 64'(m_rm[k]));
      check_eq($sformatf("d%0d.rpt_nonce", k), rn[k], m_rn[k]);
    end
    check_eq($sformatf("d%0d.found", k), 64'(fnd[k]), 64'(m_found[k]));
    check_eq($sformatf("d%0d.drop", k), 64'(drp[k]), 64'(m_drop[k]));
    check_eq($sformatf("d%0d.count", k), c, 64'(m_cnt[k]));
  endtask

  bit model_on = 0;
  int drop_pulses = 0;

  always @(negedge clk) begin
    if (drp[0]) drop_pulses++;
    if (model_on) begin
      check_dut(0);
      check_dut(1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic v, input logic [63:0] n, input int m);
    cand_valid = v;
    cand_nonce = n;
    metric     = metric_t'(m);
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(0, 0, 0);
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; cand_valid = 1'b0; cand_nonce = '0;
    metric = '0; threshold = metric_t'(4); rpt_ready = 1'b0;
    model_reset();
    #2;
    check_eq("reset.best_valid", 64'(bv[0]), 64'd0);
    check_eq("reset.count", 64'(cnt1), 64'd0);
    check_eq("reset.rpt_valid", 64'(rv[0]), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_on = 1;

    // Basic tracking, LAT=1
    tick(1, 5, 0); tick(1, 6, 3); tick(1, 7, 9); tick(0, 0, 9);
    check_eq("s1.best_metric", 64'(bm[0]), 64'd9);
    check_eq("s1.best_nonce", bn[0], 64'd6);
    check_eq("s1.rpt_valid", 64'(rv[0]), 64'd1);
    check_eq("s1.rpt_nonce", rn[0], 64'd6);
    check_eq("s1.count", 64'(cnt1), 64'd3);
    rpt_ready = 1'b1; tick(0, 0, 0); rpt_ready = 1'b0;
    check_eq("s1.accepted", 64'(rv[0]), 64'd0);

    // Backpressure overwrite
    do_clear();
    drop_pulses = 0;
    tick(1, 'h10, 0); tick(1, 'h11, 10); tick(0, 0, 12); tick(0, 0, 0); tick(0, 0, 0);
    check_eq("s2.rpt_metric", 64'(rm[0]), 64'd12);
    check_eq("s2.rpt_nonce", rn[0], 64'h11);
    check_eq("s2.drop_pulses", 64'(drop_pulses), 64'd1);

    // Accept and load in the same cycle
    tick(1, 'h12, 0);
    rpt_ready = 1'b1; tick(0, 0, 15); rpt_ready = 1'b0;
    check_eq("s3.rpt_valid", 64'(rv[0]), 64'd1);
    check_eq("s3.rpt_metric", 64'(rm[0]), 64'd15);
    check_eq("s3.drop", 64'(drp[0]), 64'd0);

    // Full match, then saturated illegal metric ties
    tick(1, 'h20, 0); tick(1, 'h21, 160); tick(0, 0, 200);
    check_eq("s4.found", 64'(fnd[0]), 64'd1);
    check_eq("s4.best_metric", 64'(bm[0]), 64'd160);
    check_eq("s4.best_nonce", bn[0], 64'h20);

    // Clear with one candidate in flight
    do_clear();
    tick(1, 'h30, 0);
    clear = 1'b1; tick(0, 0, 50); clear = 1'b0;
    check_eq("s5.best_valid", 64'(bv[0]), 64'd0);
    check_eq("s5.rpt_valid", 64'(rv[0]), 64'd0);
    check_eq("s5.found", 64'(fnd[0]), 64'd0);
    tick(0, 0, 0);
    check_eq("s5.count", 64'(cnt1), 64'd0);

    // LAT=3 alignment and 4-bit counter saturation
    do_clear();
    tick(1, 1, 0); tick(1, 2, 0); tick(1, 3, 0); tick(1, 4, 2);
    tick(0, 0, 8); tick(0, 0, 4); tick(0, 0, 6); tick(0, 0, 0);
    check_eq("s6.best_nonce", bn[1], 64'd2);
    check_eq("s6.best_metric", 64'(bm[1]), 64'd8);
    check_eq("s6.count", 64'(cnt3), 64'd4);
    for (int i = 0; i < 20; i++) tick(1, 64'(100 + i), 1);
    tick(0, 0, 0); tick(0, 0, 0); tick(0, 0, 0);
    check_eq("s6.count_sat", 64'(cnt3), 64'd15);

    // Async reset mid-operation
    tick(1, 'h40, 30); tick(1, 'h41, 40);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst.best_valid", 64'(bv[0]), 64'd0);
    check_eq("rst.count3", 64'(cnt3), 64'd0);
    check_eq("rst.found", 64'(fnd[1]), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if (i % 250 == 0) begin
        case ($urandom_range(0, 3))
          0:       threshold = '0;
          1:       threshold = metric_t'(60);
          2:       threshold = metric_t'(120);
          default: threshold = metric_t'(170);
        endcase
      end
      clear     = ($urandom_range(0, 99) == 0);
      rpt_ready = ($urandom_range(0, 2) == 0);
      tick(($urandom_range(0, 9) < 7), {$urandom, $urandom}, int'($urandom_range(0, 220)));
    end
    clear = 1'b0;
    tick(0, 0, 0); tick(0, 0, 0);
    model_on = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
